// File: rtl/reg_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_file_sb: NRD-read/1-write register file with per-register busy bits  |
// | Option macro: REGFILE_BYPASS_EN (same-cycle write-through). Rev 1.0      |
// +--------------------------------------------------------------------------+
module reg_file_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                issue,
  input  logic [AW-1:0]       iaddr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             w_wr_ok;

  assign w_wr_ok = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NREGS; n++) begin
        r_regs[n] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[waddr] <= wdata;
      end
      // Issue outranks write-back: a same-cycle re-issue keeps the register pending
      r_busy[0] <= 1'b0;
      for (int n = 1; n < NREGS; n++) begin
        if (issue && (iaddr == AW'(n))) begin
          r_busy[n] <= 1'b1;
        end else if (we && (waddr == AW'(n))) begin
          r_busy[n] <= 1'b0;
        end
      end
    end
  end

  assign busy_vec = r_busy;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_raddr;
    assign w_raddr = raddr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    logic w_fwd;
    assign w_fwd = w_wr_ok && (w_raddr == waddr);
    assign rdata[i*XLEN +: XLEN] = (w_raddr == '0) ? '0 :
                                   w_fwd ? wdata : r_regs[w_raddr];
    // A forwarded value is only still pending if the same register re-issues now
    assign rbusy[i] = w_fwd ? (issue && (iaddr == waddr)) : r_busy[w_raddr];
`else
    assign rdata[i*XLEN +: XLEN] = (w_raddr == '0) ? '0 : r_regs[w_raddr];
    assign rbusy[i] = r_busy[w_raddr];
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// Self-checking bench for reg_file_sb (default parameters), bypass-aware.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        issue;
  logic [4:0]  iaddr;
  logic [31:0] busy_vec;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .issue(issue),
    .iaddr(iaddr), .busy_vec(busy_vec)
  );

  typedef struct {
    logic rst; logic we; logic [4:0] wa; logic [31:0] wd;
    logic iss; logic [4:0] ia; logic [4:0] ra0; logic [4:0] ra1;
  } stim_t;
  typedef struct {
    logic [31:0] rd0; logic [31:0] rd1; logic [1:0] rb; logic [31:0] bv;
  } exp_t;
  typedef struct { stim_t s; exp_t e; } vec_t;
  typedef struct { string tag; exp_t e; } sb_t;

  int total = 0;
  int bad   = 0;
  sb_t q[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  vec_t tbl [17];

  function automatic stim_t mks(logic rst, logic we_i, logic [4:0] wa, logic [31:0] wd,
                                logic iss, logic [4:0] ia, logic [4:0] ra0, logic [4:0] ra1);
    stim_t s;
    s.rst = rst; s.we = we_i; s.wa = wa; s.wd = wd;
    s.iss = iss; s.ia = ia; s.ra0 = ra0; s.ra1 = ra1;
    return s;
  endfunction

  function automatic exp_t mke(logic [31:0] rd0, logic [31:0] rd1, logic [1:0] rb, logic [31:0] bv);
    exp_t e;
    e.rd0 = rd0; e.rd1 = rd1; e.rb = rb; e.bv = bv;
    return e;
  endfunction

  // Reference read path from the model state
  function automatic logic [32:0] model_port(stim_t s, logic [4:0] ra);
    logic [31:0] d;
    logic        b;
    d = (ra == 5'd0) ? 32'd0 : m_regs[ra];
    b = m_busy[ra];
`ifdef REGFILE_BYPASS_EN
    if (s.we && s.wa != 5'd0 && ra == s.wa) begin
      d = s.wd;
      b = s.iss && (s.ia == s.wa);
    end
`endif
    return {b, d};
  endfunction

  function automatic exp_t model_out(stim_t s);
    logic [32:0] p0, p1;
    p0 = model_port(s, s.ra0);
    p1 = model_port(s, s.ra1);
    return mke(p0[31:0], p1[31:0], {p1[32], p0[32]}, m_busy);
  endfunction

  task automatic model_step(stim_t s);
    if (s.rst) begin
      for (int n = 0; n < 32; n++) m_regs[n] = 32'd0;
      m_busy = 32'd0;
    end else begin
      if (s.we && s.wa != 5'd0) m_regs[s.wa] = s.wd;
      for (int n = 1; n < 32; n++) begin
        if (s.iss && s.ia == 5'(n)) m_busy[n] = 1'b1;
        else if (s.we && s.wa == 5'(n)) m_busy[n] = 1'b0;
      end
    end
  endtask

  task automatic chk(string tag, string fld, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s %s got=%h exp=%h", tag, fld, got, exp);
    end
  endtask

  // One cycle: drive, push expectation, compare mid-cycle, advance model at the edge
  task automatic cyc(stim_t s, exp_t e, string tag);
    sb_t it;
    reset = s.rst; we = s.we; waddr = s.wa; wdata = s.wd;
    issue = s.iss; iaddr = s.ia; raddr = {s.ra1, s.ra0};
    it.tag = tag; it.e = e;
    q.push_back(it);
    @(negedge clk);
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      it = q.pop_front();
      chk(it.tag, "rdata0", rdata[31:0], it.e.rd0);
      chk(it.tag, "rdata1", rdata[63:32], it.e.rd1);
      chk(it.tag, "rbusy", {30'd0, rbusy}, {30'd0, it.e.rb});
      chk(it.tag, "busy_vec", busy_vec, it.e.bv);
    end
    @(posedge clk);
    model_step(s);
    #1;
  endtask

  initial begin
    stim_t s;
    for (int n = 0; n < 32; n++) m_regs[n] = 32'd0;
    m_busy = 32'd0;
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    issue = 1'b0; iaddr = '0; raddr = '0;
    repeat (2) @(posedge clk);
    #1;

    tbl[0]  = '{mks(0,1,5,32'hDEADBEEF,0,0,0,0), mke(0,0,2'b00,0)};
    tbl[1]  = '{mks(0,0,0,0,0,0,5,0),            mke(32'hDEADBEEF,0,2'b00,0)};
    tbl[2]  = '{mks(0,1,0,32'hFFFFFFFF,1,0,0,5), mke(0,32'hDEADBEEF,2'b00,0)};
    tbl[3]  = '{mks(0,0,0,0,1,7,0,0),            mke(0,0,2'b00,0)};
    tbl[4]  = '{mks(0,0,0,0,0,0,7,7),            mke(0,0,2'b11,32'h80)};
    tbl[5]  = '{mks(0,1,7,42,0,0,5,0),           mke(32'hDEADBEEF,0,2'b00,32'h80)};
    tbl[6]  = '{mks(0,0,0,0,0,0,7,7),            mke(42,42,2'b00,0)};
    tbl[7]  = '{mks(0,1,9,1,1,9,0,0),            mke(0,0,2'b00,0)};
    tbl[8]  = '{mks(0,0,0,0,0,0,9,7),            mke(1,42,2'b01,32'h200)};
    tbl[9]  = '{mks(0,0,0,0,1,9,9,9),            mke(1,1,2'b11,32'h200)};
    tbl[10] = '{mks(0,0,0,0,0,0,9,0),            mke(1,0,2'b01,32'h200)};
    tbl[11] = '{mks(0,1,9,77,0,0,0,0),           mke(0,0,2'b00,32'h200)};
    tbl[12] = '{mks(0,0,0,0,0,0,9,9),            mke(77,77,2'b00,0)};
    tbl[13] = '{mks(0,1,31,32'hA5A5A5A5,1,1,5,0),mke(32'hDEADBEEF,0,2'b00,0)};
    tbl[14] = '{mks(0,0,0,0,0,0,31,1),           mke(32'hA5A5A5A5,0,2'b10,32'h2)};
    tbl[15] = '{mks(1,1,4,123,1,4,31,1),         mke(32'hA5A5A5A5,0,2'b10,32'h2)};
    tbl[16] = '{mks(0,0,0,0,0,0,4,31),           mke(0,0,2'b00,0)};

    for (int i = 0; i < 17; i++) cyc(tbl[i].s, tbl[i].e, $sformatf("tbl%0d", i));

    // Forwarding corner: pending register written while being read
    cyc(mks(0,1,3,32'h11,1,3,0,0), mke(0,0,2'b00,0), "byp_a");
`ifdef REGFILE_BYPASS_EN
    cyc(mks(0,1,3,32'h55,0,0,3,3), mke(32'h55,32'h55,2'b00,32'h8), "byp_b");
    cyc(mks(0,1,3,32'h66,1,3,3,0), mke(32'h66,0,2'b01,0), "byp_c");
`else
    cyc(mks(0,1,3,32'h55,0,0,3,3), mke(32'h11,32'h11,2'b11,32'h8), "byp_b");
    cyc(mks(0,1,3,32'h66,1,3,3,0), mke(32'h55,0,2'b00,0), "byp_c");
`endif
    cyc(mks(0,0,0,0,0,0,3,3), mke(32'h66,32'h66,2'b11,32'h8), "byp_d");

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      s = mks(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
              5'($urandom_range(0, 31)), $urandom,
              ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) s.ra0 = s.wa;
      cyc(s, model_out(s), $sformatf("rnd%0d", i));
    end

    // Reset after random writes, then sweep every register
    s = mks(1,1,5'($urandom_range(1, 31)),$urandom,1,5'($urandom_range(1, 31)),0,0);
    cyc(s, model_out(s), "rst_apply");
    for (int i = 0; i < 16; i++) begin
      s = mks(0,0,0,0,0,0,5'(2*i),5'(2*i+1));
      cyc(s, mke(0,0,2'b00,0), $sformatf("rst_sweep%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
